// File: rtl/am_road_out_if.sv
// Road-output bundle between the glue stage, am_road_out and the serializer.
// The master side drives road words and serializer status; the slave is am_road_out.
interface am_road_out_if;
    logic [22:0] oadd;
    logic        dr_;
    logic        finish_road;
    logic        bitmap_en;
    logic        ser_full;
    logic        rhold;
    logic [31:0] ser_data;
    logic        ser_wen_;
    logic        overflow;
    logic        busy;

    modport master (
        output oadd, dr_, finish_road, bitmap_en, ser_full,
        input  rhold, ser_data, ser_wen_, overflow, busy
    );

    modport slave (
        input  oadd, dr_, finish_road, bitmap_en, ser_full,
        output rhold, ser_data, ser_wen_, overflow, busy
    );
endinterface

// File: rtl/am_road_out.sv
// Road output stage: buffers road/bitmap words from the glue tree, formats them
// for the serializer and closes each event with a trailer carrying the road count.
module am_road_out #(
    parameter int FIFO_DEPTH = 16,
    parameter int HOLD_THR   = 12
) (
    input  logic         clk,
    input  logic         init,
    am_road_out_if.slave road_io
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROADS,
        TRAILER
    } state_e;

    state_e            state_q, state_d;

    logic [22:0]       inData_q;
    logic              inValid_q;

    logic [31:0]       fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              phase_q, phase_d;
    logic [15:0]       roadCnt_q, roadCnt_d;
    logic [15:0]       trailerCnt_q, trailerCnt_d;

    logic              rhold_q;
    logic              overflow_q, overflow_d;
    logic [31:0]       serData_q, serData_d;
    logic              serWen_q, serWen_d;

    logic              fifoEmpty;
    logic              fifoFull;
    logic              popEn;
    logic              wrEn;
    logic              dropEn;
    logic              isBitmap;
    logic [31:0]       wrWord;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The trailer slot owns the output register, so the FIFO is not drained while in TRAILER.
    always_comb begin
        fifoEmpty = (count_q == '0);
        fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
        popEn     = !fifoEmpty && !road_io.ser_full && (state_q != TRAILER);
        wrEn      = inValid_q && (!fifoFull || popEn);
        dropEn    = inValid_q && !wrEn;
        isBitmap  = road_io.bitmap_en && phase_q;
        wrWord    = isBitmap ? {4'h1, 5'b0, inData_q} : {4'h0, 5'b0, inData_q};
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q | dropEn;
        if (wrEn) begin
            wrPtr_d = ptrInc(wrPtr_q);
        end
        if (popEn) begin
            rdPtr_d = ptrInc(rdPtr_q);
        end
        case ({wrEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The phase follows every arriving word, dropped or not, so road/bitmap pairing survives a loss.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        roadCnt_d    = roadCnt_q;
        trailerCnt_d = trailerCnt_q;
        serData_d    = serData_q;
        serWen_d     = 1'b1;

        if (inValid_q && road_io.bitmap_en) begin
            phase_d = !phase_q;
        end
        if (wrEn && !isBitmap && (roadCnt_q != 16'hFFFF)) begin
            roadCnt_d = roadCnt_q + 16'd1;
        end
        if (popEn) begin
            serData_d = fifoMem_q[rdPtr_q];
            serWen_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (inValid_q || !fifoEmpty) begin
                    state_d = ROADS;
                end
            end
            ROADS: begin
                // Count is snapshotted here so words arriving during TRAILER belong to the next event.
                if (road_io.finish_road && !inValid_q && fifoEmpty) begin
                    state_d      = TRAILER;
                    trailerCnt_d = roadCnt_q;
                    roadCnt_d    = 16'd0;
                    phase_d      = 1'b0;
                end
            end
            TRAILER: begin
                if (!road_io.ser_full) begin
                    serData_d = {4'hE, 12'b0, trailerCnt_q};
                    serWen_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q      <= IDLE;
            inData_q     <= '0;
            inValid_q    <= 1'b0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            phase_q      <= 1'b0;
            roadCnt_q    <= 16'd0;
            trailerCnt_q <= 16'd0;
            rhold_q      <= 1'b0;
            overflow_q   <= 1'b0;
            serData_q    <= 32'd0;
            serWen_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            inData_q     <= road_io.oadd;
            inValid_q    <= !road_io.dr_;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            roadCnt_q    <= roadCnt_d;
            trailerCnt_q <= trailerCnt_d;
            rhold_q      <= (count_q >= CNT_W'(HOLD_THR));
            overflow_q   <= overflow_d;
            serData_q    <= serData_d;
            serWen_q     <= serWen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            fifoMem_q[wrPtr_q] <= wrWord;
        end
    end

    assign road_io.rhold    = rhold_q;
    assign road_io.ser_data = serData_q;
    assign road_io.ser_wen_ = serWen_q;
    assign road_io.overflow = overflow_q;
    assign road_io.busy     = (state_q != IDLE);

endmodule

// File: doc/am_road_out.md
AM_ROAD_OUT -- requirements
Module: am_road_out

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: number of entries in the internal road buffer.
REQ-002 SHALL have parameter HOLD_THR, default 12: buffer occupancy at or above which rhold asserts.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port init, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port oadd, input, 23 bits: road or bitmap word from the upstream glue stage.
REQ-006 SHALL have port dr_, input, 1 bit: active-low data ready; oadd is valid in any cycle where dr_=0.
REQ-007 SHALL have port finish_road, input, 1 bit: level, high when the glue tree has drained.
REQ-008 SHALL have port bitmap_en, input, 1 bit: when high, each road word is followed by one bitmap word.
REQ-009 SHALL have port ser_full, input, 1 bit: downstream serializer cannot accept a word this cycle.
REQ-010 SHALL have port rhold, output, 1 bit: back-pressure to the glue stage.
REQ-011 SHALL have port ser_data, output, 32 bits: formatted word to the serializer.
REQ-012 SHALL have port ser_wen_, output, 1 bit: active-low write strobe; one word per low cycle.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a word was lost.
REQ-014 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.

Function
REQ-015 Capture: SHALL register {oadd, !dr_} into an input stage each cycle; a valid input-stage word is written into the FIFO on the next edge.
REQ-016 Word type: with bitmap_en=0 every word SHALL be a road. With bitmap_en=1 a phase bit SHALL alternate road, bitmap, road, ... starting with road; the phase bit clears on init and after each trailer.
REQ-017 Format: road = {4'h0, 5'b0, oadd}; bitmap = {4'h1, 5'b0, oadd}; trailer = {4'hE, 12'b0, road_cnt[15:0]}.
REQ-018 road_cnt SHALL count road words (not bitmaps) written to the FIFO since the last trailer, saturating at 16'hFFFF.
REQ-019 rhold SHALL be registered and high in the cycle after FIFO occupancy >= HOLD_THR, low in the cycle after occupancy < HOLD_THR.
REQ-020 Full: a write to a full FIFO with no simultaneous read SHALL drop the word and set overflow; simultaneous read and write at full SHALL not drop.
REQ-021 Output: when the FIFO is non-empty and ser_full=0, one word SHALL be popped into the registered ser_data with ser_wen_=0 on the next cycle; otherwise ser_wen_=1 and ser_data holds.
REQ-022 Latency: dr_=0 in cycle N, empty FIFO, ser_full=0 -> ser_wen_=0 with that word in cycle N+3.
REQ-023 FSM states IDLE, ROADS, TRAILER.
REQ-024 IDLE -> ROADS when the input stage holds a valid word.
REQ-025 ROADS -> TRAILER when finish_road=1, the input stage is empty, the FIFO is empty, and no word is being popped.
REQ-026 TRAILER: SHALL emit the trailer word when ser_full=0, clear road_cnt and the phase bit, then go to IDLE; it SHALL wait in TRAILER while ser_full=1.
REQ-027 finish_road high in IDLE SHALL produce no trailer, so an event with no roads gives no output.
REQ-028 Input words arriving while in TRAILER SHALL be buffered and counted toward the next event, not the current trailer.
REQ-029 ser_full=1 SHALL never cause loss; buffering and rhold alone absorb it.

Reset
REQ-030 init=1 at a clock edge SHALL give: FIFO empty, input stage invalid, state IDLE, road_cnt=0, phase=road, rhold=0, ser_wen_=1, ser_data=0, overflow=0, busy=0.
REQ-031 init asserted mid-event SHALL discard buffered words without emitting a trailer.

Verification
REQ-032 Single road: oadd=23'h012345, dr_=0 for 1 cycle, then finish_road=1 -> ser_data=32'h00012345 at N+3, then trailer 32'hE0000001.
REQ-033 Bitmap mode: bitmap_en=1, 2 consecutive words 23'h000010 and 23'h7FFFFF -> 32'h00000010, 32'h107FFFFF, trailer 32'hE0000001.
REQ-034 Back-pressure: ser_full=1, 14 consecutive words -> rhold high after occupancy reaches 12; release ser_full -> all 14 words out in order, then trailer 32'hE000000E, overflow=0.
REQ-035 Overflow: ser_full=1, rhold ignored, 20 words -> the first 16 are delivered, overflow=1, trailer count 32'hE0000010.
REQ-036 finish_road=1 with no input since reset -> ser_wen_ stays 1 and busy=0.
REQ-037 init pulsed with 5 words buffered -> no further ser_wen_ strobes; the next event's trailer counts only new roads.
